// File: rtl/weight_buffer_mc.sv
// weight_buffer_mc: fetches a group of CH kernels (CH*KSIZE^2 words) over an
// AXI-style read channel in bursts of up to BURST beats into a ping-pong bank
// pair, and replays the active bank tap by tap to CH parallel lanes while the
// other bank is being filled.
// Optional build macro WB_RLAST_CHK_EN adds a sticky 'err' output that flags
// any accepted beat whose rlast disagrees with the internal burst counter.
module weight_buffer_mc #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned KSIZE = 3,
  parameter int unsigned CH    = 4,
  parameter int unsigned BURST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    init_addr,
  input  logic             init_addr_en,
  input  logic             weight_load,
  output logic             load_busy,
  output logic [AW-1:0]    araddr,
  output logic             arvalid,
  output logic [7:0]       arlen,
  input  logic             arready,
  input  logic [DW-1:0]    rdata,
  input  logic             rvalid,
  input  logic             rlast,
  output logic             rready,
  input  logic             dw_next,
  input  logic             dw_ready,
  output logic             dw_valid,
  output logic [CH*DW-1:0] dw_out,
  output logic             dw_last_tap
`ifdef WB_RLAST_CHK_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned K2 = KSIZE * KSIZE;
  localparam int unsigned N  = CH * K2;
  localparam int unsigned WW = $clog2(N + 1);
  localparam int unsigned MW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = (K2 > 1) ? $clog2(K2) : 1;
  localparam logic [AW-1:0] BSTEP = AW'(BURST * DW / 8);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t          state;
  logic [AW-1:0]   base;
  logic [WW-1:0]   w;
  logic [7:0]      beat;
  logic            last_beat;
  logic            beat_acc;
  logic [DW-1:0]   mem [2][N];
  logic [1:0]      bank_valid;
  logic            fill_sel;
  logic            act_sel;
  logic            fill_ok;
  logic            act_valid;
  logic            swap;
  logic            pend;
  logic [TW-1:0]   tap;

  // beats-1 for the burst starting at word index wv
  function automatic logic [7:0] burst_arlen(input logic [WW-1:0] wv);
    int unsigned rem;
    rem = N - 32'(wv);
    return (rem > BURST) ? 8'(BURST - 1) : 8'(rem - 1);
  endfunction

  assign beat_acc  = (state == S_DATA) && rvalid;
  assign last_beat = (beat == arlen);

  // Loader FSM: issues bursts, counts beats, registers the AR/R handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      base      <= '0;
      w         <= '0;
      beat      <= '0;
      araddr    <= '0;
      arlen     <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      load_busy <= 1'b0;
    end else begin
      if (init_addr_en && !load_busy)
        base <= init_addr;
      unique case (state)
        S_IDLE: begin
          if (weight_load && !bank_valid[fill_sel]) begin
            state     <= S_ADDR;
            w         <= '0;
            araddr    <= base;
            arlen     <= burst_arlen('0);
            arvalid   <= 1'b1;
            load_busy <= 1'b1;
          end
        end
        S_ADDR: begin
          if (arready) begin
            state   <= S_DATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
            beat    <= '0;
            araddr  <= araddr + BSTEP;
          end
        end
        S_DATA: begin
          if (rvalid) begin
            w    <= w + WW'(1);
            beat <= beat + 8'd1;
            if (last_beat) begin
              rready <= 1'b0;
              if (w == WW'(N - 1)) begin
                state <= S_DONE;
              end else begin
                state   <= S_ADDR;
                arvalid <= 1'b1;
                arlen   <= burst_arlen(w + WW'(1));
              end
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          load_busy <= 1'b0;
        end
      endcase
    end
  end

  // Fill-bank write port; storage is channel-major (word w = channel*K2 + tap)
  always_ff @(posedge clk) begin
    if (rst_n && beat_acc)
      mem[fill_sel][MW'(w)] <= rdata;
  end

  // A bank completing in S_DONE counts as valid that same cycle, so a pending or
  // coincident dw_next (or an empty active bank) swaps without an extra bubble.
  assign act_sel   = ~fill_sel;
  assign act_valid = bank_valid[act_sel];
  assign fill_ok   = bank_valid[fill_sel] || (state == S_DONE);
  assign swap      = fill_ok && (!act_valid || dw_next || pend);

  // Bank ownership, pending-swap flag and tap pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_valid <= '0;
      fill_sel   <= 1'b0;
      pend       <= 1'b0;
      tap        <= '0;
    end else if (swap) begin
      bank_valid[fill_sel] <= 1'b1;
      bank_valid[act_sel]  <= 1'b0;
      fill_sel             <= ~fill_sel;
      pend                 <= 1'b0;
      tap                  <= '0;
    end else begin
      if (state == S_DONE)
        bank_valid[fill_sel] <= 1'b1;
      if (dw_next && act_valid)
        pend <= 1'b1;
      if (act_valid && dw_ready)
        tap <= (tap == TW'(K2 - 1)) ? '0 : tap + 1'b1;
    end
  end

  // Tap readout of all lanes from the active bank
  always_comb begin
    dw_out = '0;
    if (act_valid)
      for (int unsigned c = 0; c < CH; c++)
        dw_out[c*DW +: DW] = mem[act_sel][MW'(c * K2) + MW'(tap)];
  end

  assign dw_valid    = act_valid;
  assign dw_last_tap = act_valid && (tap == TW'(K2 - 1));

`ifdef WB_RLAST_CHK_EN
  // Sticky flag: rlast must match the internal last-beat flag on every accepted beat
  always_ff @(posedge clk) begin
    if (!rst_n)
      err <= 1'b0;
    else if (beat_acc && (rlast != last_beat))
      err <= 1'b1;
  end
`else
  logic unused_rlast;
  assign unused_rlast = rlast;
`endif

endmodule

// File: tb/tb_weight_buffer_mc.sv
// tb_weight_buffer_mc: directed bench for weight_buffer_mc with a behavioural
// AXI read responder (data word i of a group = offset + i).
module tb_weight_buffer_mc;

  logic         clk;
  logic         rst_n;
  logic [31:0]  init_addr;
  logic         init_addr_en;
  logic         weight_load;
  logic         load_busy;
  logic [31:0]  araddr;
  logic         arvalid;
  logic [7:0]   arlen;
  logic         arready;
  logic [31:0]  rdata;
  logic         rvalid;
  logic         rlast;
  logic         rready;
  logic         dw_next;
  logic         dw_ready;
  logic         dw_valid;
  logic [127:0] dw_out;
  logic         dw_last_tap;
`ifdef WB_RLAST_CHK_EN
  logic         err;
`endif

  weight_buffer_mc #(.DW(32), .AW(32), .KSIZE(3), .CH(4), .BURST(16)) dut (
    .clk(clk), .rst_n(rst_n), .init_addr(init_addr), .init_addr_en(init_addr_en),
    .weight_load(weight_load), .load_busy(load_busy), .araddr(araddr),
    .arvalid(arvalid), .arlen(arlen), .arready(arready), .rdata(rdata),
    .rvalid(rvalid), .rlast(rlast), .rready(rready), .dw_next(dw_next),
    .dw_ready(dw_ready), .dw_valid(dw_valid), .dw_out(dw_out),
    .dw_last_tap(dw_last_tap)
`ifdef WB_RLAST_CHK_EN
    , .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // responder controls (written by the main thread) and bookkeeping
  logic [31:0]  grp_base = 32'h0;
  int unsigned  off = 0;
  int unsigned  hold_cycles = 0;
  int           bad_rlast = -1;
  int unsigned  ar_wait = 0;
  int unsigned  beats_left = 0;
  int unsigned  r_idx = 0;
  int unsigned  n_ar = 0;
  int unsigned  n_beats = 0;
  logic [31:0]  ar_addr_log [64];
  logic [7:0]   ar_len_log [64];

  // Slave model: acts on the falling edge; main thread samples 1 time unit later
  always @(negedge clk) begin
    if (!rst_n) begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
      beats_left = 0; ar_wait = 0;
    end else begin
      if (rready && beats_left > 0) begin
        rvalid = 1'b1;
        rdata  = off + r_idx;
        rlast  = (beats_left == 1);
        if (int'(r_idx) == bad_rlast) rlast = ~rlast;
        r_idx++; beats_left--; n_beats++;
      end else begin
        rvalid = 1'b0; rlast = 1'b0;
      end
      if (arvalid) begin
        if (ar_wait >= hold_cycles) begin
          arready = 1'b1;
          ar_addr_log[n_ar % 64] = araddr;
          ar_len_log[n_ar % 64]  = arlen;
          n_ar++;
          beats_left = int'(arlen) + 1;
          r_idx = (araddr - grp_base) >> 2;
          ar_wait = 0;
        end else begin
          arready = 1'b0;
          ar_wait++;
        end
      end else begin
        arready = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_vec(input int unsigned o, input int unsigned t);
    logic [127:0] v;
    for (int unsigned c = 0; c < 4; c++) v[c*32 +: 32] = 32'(o + c * 9 + t);
    return v;
  endfunction

  int unsigned model_tap = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // one cycle with the tap model following dw_ready
  task automatic adv();
    tick();
    if (dw_ready) model_tap = (model_tap + 1) % 9;
  endtask

  task automatic chk_out(input string name, input int unsigned o, input int unsigned t);
    check({name, "_valid"}, 128'(dw_valid), 128'(1));
    check({name, "_data"}, dw_out, exp_vec(o, t));
    check({name, "_last"}, 128'(dw_last_tap), 128'(t == 8));
  endtask

  task automatic set_base(input logic [31:0] a);
    init_addr = a; init_addr_en = 1'b1;
    tick();
    init_addr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!load_busy) break;
      tick();
    end
    check(name, 128'(load_busy), 128'(0));
  endtask

  typedef struct { logic rdy; int unsigned tap; logic last; } vec_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  vec_t tab [20];
  ar_t  ar_exp [3];

  initial begin
    int unsigned t;
    int unsigned ar0, bt0;
    ar_exp[0] = '{32'h1000, 8'd15};
    ar_exp[1] = '{32'h1040, 8'd15};
    ar_exp[2] = '{32'h1080, 8'd3};
    t = 0;
    for (int i = 0; i < 20; i++) begin
      tab[i].tap  = t;
      tab[i].last = (t == 8);
      tab[i].rdy  = !(i == 12 || i == 13);
      if (tab[i].rdy) t = (t + 1) % 9;
    end

    rst_n = 1'b0; init_addr = '0; init_addr_en = 1'b0; weight_load = 1'b0;
    dw_next = 1'b0; dw_ready = 1'b0;
    repeat (3) tick();
    check("rst_arvalid", 128'(arvalid), 128'(0));
    check("rst_araddr", 128'(araddr), 128'(0));
    check("rst_arlen", 128'(arlen), 128'(0));
    check("rst_rready", 128'(rready), 128'(0));
    check("rst_busy", 128'(load_busy), 128'(0));
    check("rst_dw_valid", 128'(dw_valid), 128'(0));
    check("rst_dw_out", dw_out, 128'(0));
    check("rst_last", 128'(dw_last_tap), 128'(0));
`ifdef WB_RLAST_CHK_EN
    check("rst_err", 128'(err), 128'(0));
`endif
    rst_n = 1'b1;
    tick();

    // group A: base 0x1000, data i
    grp_base = 32'h1000; off = 0;
    set_base(32'h1000);
    ar0 = n_ar; bt0 = n_beats;
    weight_load = 1'b1; tick(); weight_load = 1'b0;
    wait_idle("A_busy_fall", 200);
    check("A_beats", 128'(n_beats - bt0), 128'(36));
    check("A_nbursts", 128'(n_ar - ar0), 128'(3));
    for (int k = 0; k < 3; k++) begin
      check("A_araddr", 128'(ar_addr_log[(ar0 + k) % 64]), 128'(ar_exp[k].addr));
      check("A_arlen", 128'(ar_len_log[(ar0 + k) % 64]), 128'(ar_exp[k].len));
    end
    for (int i = 0; i < 3; i++) begin
      if (dw_valid) break;
      tick();
    end
    check("A_autopromote", 128'(dw_valid), 128'(1));

    // replay table
    for (int i = 0; i < 20; i++) begin
      check("replay_data", dw_out, exp_vec(0, tab[i].tap));
      check("replay_last", 128'(dw_last_tap), 128'(tab[i].last));
      check("replay_valid", 128'(dw_valid), 128'(1));
      dw_ready = tab[i].rdy;
      tick();
    end
    model_tap = t;

    // group B loads behind A; A keeps replaying; dw_next at tap 4 swaps
    grp_base = 32'h2000; off = 100;
    set_base(32'h2000); model_tap = (model_tap + 1) % 9;
    chk_out("A_during_B", 0, model_tap);
    weight_load = 1'b1; adv(); weight_load = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk_out("A_during_B", 0, model_tap);
      if (!load_busy) break;
      adv();
    end
    check("B_busy_fall", 128'(load_busy), 128'(0));
    for (int i = 0; i < 10; i++) begin
      if (model_tap == 4) break;
      adv();
    end
    chk_out("A_tap4", 0, 4);
    dw_next = 1'b1; adv(); dw_next = 1'b0;
    model_tap = 0;
    chk_out("B_swap", 100, 0);

    // dw_next while C still loading: pending until DONE
    grp_base = 32'h3000; off = 200;
    set_base(32'h3000); model_tap = (model_tap + 1) % 9;
    weight_load = 1'b1; adv(); weight_load = 1'b0;
    chk_out("B_during_C", 100, model_tap);
    dw_next = 1'b1; adv(); dw_next = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!load_busy) begin
        model_tap = 0;
        chk_out("C_swap", 200, 0);
        break;
      end
      chk_out("B_pending", 100, model_tap);
      adv();
    end
    check("C_busy_fall", 128'(load_busy), 128'(0));
    adv();
    chk_out("C_tap1", 200, model_tap);

    // group D with arready held low; busy weight_load / init_addr_en ignored
    dw_ready = 1'b0;
    grp_base = 32'h4000; off = 300; hold_cycles = 5;
    set_base(32'h4000);
    ar0 = n_ar; bt0 = n_beats;
    weight_load = 1'b1; tick(); weight_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_arvalid", 128'(arvalid), 128'(1));
      check("hold_araddr", 128'(araddr), 128'(32'h4000));
      check("hold_arlen", 128'(arlen), 128'(15));
      if (i == 1) begin
        weight_load = 1'b1; init_addr = 32'hDEAD_0000; init_addr_en = 1'b1;
      end else begin
        weight_load = 1'b0; init_addr_en = 1'b0;
      end
      tick();
    end
    wait_idle("D_busy_fall", 400);
    hold_cycles = 0;
    check("D_nbursts", 128'(n_ar - ar0), 128'(3));
    check("D_beats", 128'(n_beats - bt0), 128'(36));
    repeat (3) tick();
    check("D_no_reload", 128'(load_busy), 128'(0));
    check("D_no_reload_ar", 128'(n_ar - ar0), 128'(3));
    chk_out("C_held", 200, 1);
    dw_next = 1'b1; tick(); dw_next = 1'b0;
    chk_out("D_swap", 300, 0);

    // reset in the middle of a data burst
    off = 500;
    weight_load = 1'b1; tick(); weight_load = 1'b0;
    check("base_kept", 128'(araddr), 128'(32'h4000));
    for (int i = 0; i < 20; i++) begin
      if (rready) break;
      tick();
    end
    check("E_rready", 128'(rready), 128'(1));
    repeat (2) tick();
    rst_n = 1'b0; tick();
    check("mid_rst_dw_valid", 128'(dw_valid), 128'(0));
    check("mid_rst_arvalid", 128'(arvalid), 128'(0));
    check("mid_rst_rready", 128'(rready), 128'(0));
    check("mid_rst_busy", 128'(load_busy), 128'(0));
    check("mid_rst_dw_out", dw_out, 128'(0));
    rst_n = 1'b1; tick();

    // clean load after reset
    grp_base = 32'h5000; off = 400;
    set_base(32'h5000);
    weight_load = 1'b1; tick(); weight_load = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dw_valid) break;
      tick();
    end
    chk_out("F_tap0", 400, 0);
    dw_ready = 1'b1;
    repeat (8) tick();
    dw_ready = 1'b0;
    chk_out("F_tap8", 400, 8);

`ifdef WB_RLAST_CHK_EN
    check("err_clean", 128'(err), 128'(0));
    grp_base = 32'h6000; off = 600; bad_rlast = 10;
    set_base(32'h6000);
    weight_load = 1'b1; tick(); weight_load = 1'b0;
    wait_idle("G_busy_fall", 200);
    check("err_set", 128'(err), 128'(1));
    repeat (4) tick();
    check("err_sticky", 128'(err), 128'(1));
    dw_next = 1'b1; dw_ready = 1'b1; tick(); dw_next = 1'b0;
    chk_out("G_tap0", 600, 0);
    tick(); dw_ready = 1'b0;
    chk_out("G_tap1", 600, 1);
    bad_rlast = -1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
